// File: rtl/adaptive_filter_pkg.sv
// Shared types for the adaptive filter and its downstream stages.
package adaptive_filter_pkg;

  localparam int unsigned AF_DATA_WIDTH = 14;

  typedef logic signed [AF_DATA_WIDTH-1:0] af_sample_t;

endpackage

// File: rtl/af_sync_fifo.sv
// Pointer-based first-word-fall-through FIFO with occupancy output.
module af_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic                           valid_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;

  assign valid_o   = (level_q != '0);
  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign level_o   = level_q;
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/af_out_decimator.sv
// Drops filter settling transients, averages groups of 2**DECIM_LOG2 samples
// with round-half-up, and streams results through a FWFT FIFO.
module af_out_decimator
  import adaptive_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = AF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int unsigned DECIM_LOG2    = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic                               ctrl,
  input  logic [DATA_WIDTH-1:0]              s_tdata,
  output logic [OUT_WIDTH-1:0]               m_tdata,
  output logic                               m_tuser,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               ovf_sticky,
  input  logic                               clr_ovf
);

  localparam int unsigned ACC_W = DATA_WIDTH + DECIM_LOG2 + 1;
  localparam int unsigned CNT_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam int unsigned SET_W = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic signed [ACC_W-1:0]  ROUND    = ACC_W'((1 << DECIM_LOG2) >> 1);
  localparam logic signed [DATA_WIDTH-1:0] D_MAX = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  S_MAX    = ACC_W'(D_MAX);
  localparam logic signed [ACC_W-1:0]  S_MIN    = ~S_MAX;

  logic                          ctrl_q, ctrl_d;
  logic [SET_W-1:0]              settle_q, settle_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic                          tuser_q, tuser_d;
  logic                          ovf_q, ovf_d;

  logic signed [ACC_W-1:0]       sample_ext, sum, avg;
  logic signed [DATA_WIDTH-1:0]  res_sat;
  logic                          push, push_tuser, pop, fifo_full, drop;
  logic [OUT_WIDTH:0]            rd_data;

  assign sample_ext = ACC_W'($signed(s_tdata));
  assign sum        = acc_q + sample_ext + ROUND;
  assign avg        = sum >>> DECIM_LOG2;
  assign push_tuser = (cnt_q == '0) ? ctrl_q : tuser_q;
  assign pop        = m_tvalid && m_tready;
  assign drop       = push && fifo_full && !pop;

  // Saturate the average to the input sample range.
  always_comb begin
    res_sat = DATA_WIDTH'(avg);
    if (avg > S_MAX)      res_sat = D_MAX;
    else if (avg < S_MIN) res_sat = ~D_MAX;
  end

  // Mode-edge / settle / accumulate sequencing.
  always_comb begin
    ctrl_d   = ctrl;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    tuser_d  = tuser_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    if (ctrl != ctrl_q) begin
      settle_d = SET_W'(SETTLE_CYCLES);
      cnt_d    = '0;
      acc_d    = '0;
    end else if (settle_q != '0) begin
      settle_d = settle_q - SET_W'(1);
    end else begin
      if (cnt_q == '0) tuser_d = ctrl_q;
      if (cnt_q == LAST_CNT) begin
        push  = 1'b1;
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_q + sample_ext;
      end
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ctrl_q   <= ctrl;
      settle_q <= SET_W'(SETTLE_CYCLES);
      cnt_q    <= '0;
      acc_q    <= '0;
      tuser_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      tuser_q  <= tuser_d;
      ovf_q    <= ovf_d;
    end
  end

  af_sync_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (srst),
    .push_i    (push),
    .wr_data_i ({push_tuser, OUT_WIDTH'(res_sat)}),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .valid_o   (m_tvalid),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

  assign m_tdata    = rd_data[OUT_WIDTH-1:0];
  assign m_tuser    = rd_data[OUT_WIDTH];
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_af_out_decimator.sv
// Directed bench for af_out_decimator: default build plus a pass-through build.
module tb_af_out_decimator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, ctrl, m_tready, clr_ovf;
  logic [13:0] s_tdata;
  logic [15:0] m_tdata;
  logic        m_tuser, m_tvalid, ovf_sticky;
  logic [3:0]  fifo_level;

  logic        srst0, ctrl0, rdy0, clr0;
  logic [13:0] s0;
  logic [15:0] data0;
  logic        tuser0, valid0, ovf0;
  logic [3:0]  level0;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  af_out_decimator dut (
    .clk(clk), .srst(srst), .ctrl(ctrl), .s_tdata(s_tdata),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .fifo_level(fifo_level), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  af_out_decimator #(.DECIM_LOG2(0)) dut0 (
    .clk(clk), .srst(srst0), .ctrl(ctrl0), .s_tdata(s0),
    .m_tdata(data0), .m_tuser(tuser0), .m_tvalid(valid0), .m_tready(rdy0),
    .fifo_level(level0), .ovf_sticky(ovf0), .clr_ovf(clr0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input int v0, input int v1, input int v2, input int v3);
    int v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      s_tdata = 14'(v[i]);
      tick();
    end
  endtask

  initial begin
    srst = 1'b1; ctrl = 1'b0; s_tdata = '0; m_tready = 1'b1; clr_ovf = 1'b0;
    srst0 = 1'b1; ctrl0 = 1'b0; s0 = '0; rdy0 = 1'b1; clr0 = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(m_tvalid), 32'd0);
    chk("rst_data",  32'(m_tdata),  32'd0);
    chk("rst_tuser", 32'(m_tuser),  32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf",   32'(ovf_sticky), 32'd0);

    // Constant 100: 8 settle + 4 samples before the first result
    srst = 1'b0; s_tdata = 14'd100;
    repeat (11) tick();
    chk("t1_early_valid", 32'(m_tvalid), 32'd0);
    tick();
    chk("t1_valid", 32'(m_tvalid), 32'd1);
    chk("t1_data",  32'(m_tdata),  32'd100);
    chk("t1_tuser", 32'(m_tuser),  32'd0);
    tick();
    chk("t1_popped", 32'(m_tvalid), 32'd0);
    repeat (3) tick();
    chk("t1_valid2", 32'(m_tvalid), 32'd1);
    chk("t1_data2",  32'(m_tdata),  32'd100);

    // Rounding and extremes
    send4(1, 1, 0, 0);
    chk("t2_half_up", 32'(m_tdata), 32'h0001);
    chk("t2_level",   32'(fifo_level), 32'd1);
    send4(-1, -1, 0, 0);
    chk("t2_neg_half", 32'(m_tdata), 32'h0000);
    send4(1, 2, 2, 2);
    chk("t2_pos", 32'(m_tdata), 32'h0002);
    send4(-1, -2, -2, -2);
    chk("t2_neg", 32'(m_tdata), 32'hFFFE);
    send4(8191, 8191, 8191, 8191);
    chk("t3_max", 32'(m_tdata), 32'h1FFF);
    send4(-8192, -8192, -8192, -8192);
    chk("t3_min", 32'(m_tdata), 32'hE000);

    // Backpressure, overflow and sticky clear
    srst = 1'b1; tick(); srst = 1'b0; s_tdata = '0;
    repeat (8) tick();
    m_tready = 1'b0;
    for (int k = 1; k <= 8; k++) send4(10 * k, 10 * k, 10 * k, 10 * k);
    chk("t4_level_full", 32'(fifo_level), 32'd8);
    chk("t4_no_ovf",     32'(ovf_sticky), 32'd0);
    chk("t4_head",       32'(m_tdata),    32'd10);
    send4(90, 90, 90, 90);
    chk("t4_ovf",        32'(ovf_sticky), 32'd1);
    chk("t4_level_held", 32'(fifo_level), 32'd8);
    s_tdata = 14'd100; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t4_clr", 32'(ovf_sticky), 32'd0);
    tick(); tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(ovf_sticky), 32'd1);

    // Drain in order while a mode edge suppresses new results
    m_tready = 1'b1; ctrl = 1'b1; s_tdata = 14'd7;
    for (int d = 1; d <= 8; d++) begin
      chk("t4_drain", 32'(m_tdata), 32'(10 * d));
      tick();
    end
    chk("t4_drained_level", 32'(fifo_level), 32'd0);
    chk("t4_drained_valid", 32'(m_tvalid),   32'd0);
    repeat (4) tick();
    chk("t5_quiet12", 32'(m_tvalid), 32'd0);
    tick();
    chk("t5_valid", 32'(m_tvalid), 32'd1);
    chk("t5_data",  32'(m_tdata),  32'd7);
    chk("t5_tuser", 32'(m_tuser),  32'd1);

    // Partial group discarded; second edge during settle restarts the count
    s_tdata = 14'd1000;
    for (int i = 1; i <= 17; i++) begin
      if (i == 3) begin ctrl = 1'b0; s_tdata = 14'd4; end
      if (i == 6) ctrl = 1'b1;
      tick();
      chk("t5_quiet", 32'(m_tvalid), 32'd0);
    end
    tick();
    chk("t5_restart_valid", 32'(m_tvalid), 32'd1);
    chk("t5_restart_data",  32'(m_tdata),  32'd4);
    chk("t5_restart_tuser", 32'(m_tuser),  32'd1);

    // Reset mid-operation with entries held
    m_tready = 1'b0;
    repeat (8) tick();
    chk("t6_level3", 32'(fifo_level), 32'd3);
    chk("t6_ovf_pre", 32'(ovf_sticky), 32'd1);
    srst = 1'b1; tick();
    chk("t6_valid", 32'(m_tvalid),   32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_ovf",   32'(ovf_sticky), 32'd0);
    chk("t6_data",  32'(m_tdata),    32'd0);
    srst = 1'b0; m_tready = 1'b1;
    repeat (11) tick();
    chk("t6_early", 32'(m_tvalid), 32'd0);
    tick();
    chk("t6_back",      32'(m_tvalid), 32'd1);
    chk("t6_back_data", 32'(m_tdata),  32'd4);

    // Pass-through build: one result per sample, latency 1
    srst0 = 1'b0; s0 = 14'(-5);
    repeat (8) tick();
    chk("t3p_settle", 32'(valid0), 32'd0);
    tick();
    chk("t3p_valid", 32'(valid0), 32'd1);
    chk("t3p_data",  32'(data0),  32'hFFFB);
    s0 = 14'd3; tick();
    chk("t3p_next",  32'(data0),  32'h0003);
    chk("t3p_level", 32'(level0), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
